rect_painter: RTL and testbench

RECT_PAINTER -- requirements
Module: rect_painter

---
 rtl/rect_painter_pkg.sv | 27 ++
 rtl/rect_painter_if.sv | 28 ++
 rtl/coor_to_offset.sv | 12 +
 rtl/rect_painter.sv | 122 ++++++++++++
 tb/tb_rect_painter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rect_painter_pkg.sv
// Shared definitions for the rectangle painter and the screen flasher:
// frame-buffer geometry, FSM encoding and the bound-clipping helper.
package rect_painter_pkg;

    localparam int SCR_WIDTH  = 112;
    localparam int SCR_HEIGHT = 112;
    localparam int ADDR_SIZE  = 14;
    localparam int COLOR_SIZE = 3;
    localparam int COOR_SIZE  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // 8-bit sum cannot wrap for two 7-bit operands, so the min() is exact.
    function automatic logic [7:0] clip_end(input logic [6:0] start,
                                            input logic [6:0] len,
                                            input logic [7:0] limit);
        logic [7:0] sum;
        sum = {1'b0, start} + {1'b0, len};
        return (sum > limit) ? limit : sum;
    endfunction

endpackage

// File: rtl/rect_painter_if.sv
// Start/geometry request, frame-buffer write port and continuation handshake.
interface rect_painter_if #(
    parameter int ADDR_SIZE  = rect_painter_pkg::ADDR_SIZE,
    parameter int COLOR_SIZE = rect_painter_pkg::COLOR_SIZE
);
    logic                  in_cont_signal;
    logic [6:0]            rect_x;
    logic [6:0]            rect_y;
    logic [6:0]            rect_w;
    logic [6:0]            rect_h;
    logic [COLOR_SIZE-1:0] rect_color;
    logic [ADDR_SIZE-1:0]  write_addr;
    logic [COLOR_SIZE-1:0] write_data;
    logic                  write_en;
    logic                  out_cont_signal;
    logic                  next_fin_signal;
    logic                  busy;

    modport master (
        output in_cont_signal, rect_x, rect_y, rect_w, rect_h, rect_color, next_fin_signal,
        input  write_addr, write_data, write_en, out_cont_signal, busy
    );

    modport slave (
        input  in_cont_signal, rect_x, rect_y, rect_w, rect_h, rect_color, next_fin_signal,
        output write_addr, write_data, write_en, out_cont_signal, busy
    );
endinterface

// File: rtl/coor_to_offset.sv
// Linear frame-buffer offset of pixel (x, y); shared with the screen flasher.
module coor_to_offset #(
    parameter int COOR_SIZE = 8,
    parameter int SCR_WIDTH = rect_painter_pkg::SCR_WIDTH,
    parameter int ADDR_SIZE = rect_painter_pkg::ADDR_SIZE
) (
    input  logic [COOR_SIZE-1:0] x_i,
    input  logic [COOR_SIZE-1:0] y_i,
    output logic [ADDR_SIZE-1:0] offset_o
);
    assign offset_o = ADDR_SIZE'(x_i) + ADDR_SIZE'(y_i) * ADDR_SIZE'(SCR_WIDTH);
endmodule

// File: rtl/rect_painter.sv
// Fills a clipped rectangle into the frame buffer one pixel per cycle, then
// raises out_cont_signal until the downstream block reports it has finished.
module rect_painter #(
    parameter int SCR_WIDTH  = rect_painter_pkg::SCR_WIDTH,
    parameter int SCR_HEIGHT = rect_painter_pkg::SCR_HEIGHT,
    parameter int ADDR_SIZE  = rect_painter_pkg::ADDR_SIZE,
    parameter int COLOR_SIZE = rect_painter_pkg::COLOR_SIZE
) (
    input  logic          Clck,
    input  logic          Reset,
    rect_painter_if.slave bus
);
    import rect_painter_pkg::*;

    localparam logic [7:0] W8 = 8'(SCR_WIDTH);
    localparam logic [7:0] H8 = 8'(SCR_HEIGHT);

    state_t                state_q;
    logic [6:0]            rx_q, ry_q, rw_q, rh_q;
    logic [COLOR_SIZE-1:0] color_q;
    logic [7:0]            x_q, y_q, x_end_q, y_end_q;
    logic [ADDR_SIZE-1:0]  addr_q;
    logic [COLOR_SIZE-1:0] data_q;
    logic                  wen_q, out_cont_q, busy_q;

    logic [7:0]            x_end_d, y_end_d;
    logic                  empty_d, col_last, row_last;
    logic [ADDR_SIZE-1:0]  offset;

    assign x_end_d  = clip_end(rx_q, rw_q, W8);
    assign y_end_d  = clip_end(ry_q, rh_q, H8);
    // Nothing visible on screen: skip straight to completion.
    assign empty_d  = (rw_q == 7'd0) || (rh_q == 7'd0)
                   || ({1'b0, rx_q} >= W8) || ({1'b0, ry_q} >= H8);
    assign col_last = (x_q + 8'd1) == x_end_q;
    assign row_last = (y_q + 8'd1) == y_end_q;

    coor_to_offset #(
        .COOR_SIZE (8),
        .SCR_WIDTH (SCR_WIDTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_offset (
        .x_i      (x_q),
        .y_i      (y_q),
        .offset_o (offset)
    );

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            rx_q       <= '0;
            ry_q       <= '0;
            rw_q       <= '0;
            rh_q       <= '0;
            color_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wen_q      <= 1'b0;
            out_cont_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_cont_signal) begin
                        rx_q    <= bus.rect_x;
                        ry_q    <= bus.rect_y;
                        rw_q    <= bus.rect_w;
                        rh_q    <= bus.rect_h;
                        color_q <= bus.rect_color;
                        busy_q  <= 1'b1;
                        state_q <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    x_end_q <= x_end_d;
                    y_end_q <= y_end_d;
                    x_q     <= {1'b0, rx_q};
                    y_q     <= {1'b0, ry_q};
                    state_q <= empty_d ? ST_DONE : ST_WRITE;
                end
                ST_WRITE: begin
                    wen_q  <= 1'b1;
                    addr_q <= offset;
                    data_q <= color_q;
                    if (col_last) begin
                        x_q <= {1'b0, rx_q};
                        if (row_last) begin
                            state_q <= ST_DONE;
                        end else begin
                            y_q <= y_q + 8'd1;
                        end
                    end else begin
                        x_q <= x_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    // Release only after out_cont_signal has actually been seen high.
                    if (out_cont_q && bus.next_fin_signal) begin
                        out_cont_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        out_cont_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.write_addr      = addr_q;
    assign bus.write_data      = data_q;
    assign bus.write_en        = wen_q;
    assign bus.out_cont_signal = out_cont_q;
    assign bus.busy            = busy_q;

endmodule

// File: tb/tb_rect_painter.sv
// Scoreboard bench for rect_painter: expected pixels queued per fill, popped on write_en.
module tb_rect_painter;

    logic Clck  = 1'b0;
    logic Reset = 1'b0;
    always #5 Clck = ~Clck;

    rect_painter_if #(.ADDR_SIZE(14), .COLOR_SIZE(3)) bus();

    rect_painter #(
        .SCR_WIDTH  (112),
        .SCR_HEIGHT (112),
        .ADDR_SIZE  (14),
        .COLOR_SIZE (3)
    ) dut (
        .Clck  (Clck),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [13:0] addr;
        logic [2:0]  data;
    } pix_t;

    pix_t sb[$];
    pix_t exp_pix;
    int   err_cnt  = 0;
    int   chk_cnt  = 0;
    int   cyc      = 0;
    int   wr_count = 0;
    int   wr_first = -1;
    int   wr_last  = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge Clck);
        cyc++;
    end

    // Monitor: every observed write is matched against the head of the scoreboard.
    initial forever begin
        @(negedge Clck);
        if (bus.write_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected_sb_size", sb.size(), 1);
            end else begin
                exp_pix = sb.pop_front();
                chk("wr_addr", bus.write_addr, exp_pix.addr);
                chk("wr_data", bus.write_data, exp_pix.data);
            end
            wr_count++;
            if (wr_first < 0) wr_first = cyc;
            wr_last = cyc;
        end
    end

    function automatic int clip(input int s, input int l, input int lim);
        return (s + l > lim) ? lim : s + l;
    endfunction

    task automatic push_expected(input int x, input int y, input int w, input int h,
                                 input int c, output int n);
        int xe, ye;
        xe = clip(x, w, 112);
        ye = clip(y, h, 112);
        n  = 0;
        for (int yy = y; yy < ye; yy++) begin
            for (int xx = x; xx < xe; xx++) begin
                sb.push_back('{addr: 14'(xx + yy * 112), data: 3'(c)});
                n++;
            end
        end
    endtask

    task automatic start_fill(input int x, input int y, input int w, input int h, input int c);
        @(negedge Clck);
        bus.rect_x         = 7'(x);
        bus.rect_y         = 7'(y);
        bus.rect_w         = 7'(w);
        bus.rect_h         = 7'(h);
        bus.rect_color     = 3'(c);
        bus.in_cont_signal = 1'b1;
    endtask

    task automatic run_fill(input int x, input int y, input int w, input int h,
                            input int c, input bit noise);
        int  n, start_cyc, base_cnt, rise;
        bit  seen;
        push_expected(x, y, w, h, c, n);
        start_fill(x, y, w, h, c);
        base_cnt = wr_count;
        wr_first = -1;
        @(posedge Clck);
        #1;
        start_cyc          = cyc;
        bus.in_cont_signal = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        seen = 1'b0;
        rise = -1;
        for (int k = 0; k < n + 40 && !seen; k++) begin
            @(posedge Clck);
            #2;
            if (bus.out_cont_signal === 1'b1) begin
                seen = 1'b1;
                rise = cyc;
            end else if (noise) begin
                bus.in_cont_signal = 1'($urandom);
                bus.rect_x         = 7'($urandom);
                bus.rect_y         = 7'($urandom);
                bus.rect_w         = 7'($urandom);
                bus.rect_color     = 3'($urandom);
            end
        end
        if (!seen) chk("out_cont_timeout", bus.out_cont_signal, 1);
        chk("out_cont_latency", rise - start_cyc, n + 2);
        chk("wr_count", wr_count - base_cnt, n);
        if (n > 0) begin
            chk("first_wr_latency", wr_first - start_cyc, 2);
            chk("wr_contiguous", wr_last - wr_first + 1, n);
        end
        chk("sb_drained", sb.size(), 0);
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            @(posedge Clck);
            #2;
            chk("out_cont_hold", bus.out_cont_signal, 1);
            chk("wen_low_done", bus.write_en, 0);
            bus.in_cont_signal = ~bus.in_cont_signal;
        end
        @(negedge Clck);
        bus.next_fin_signal = 1'b1;
        bus.in_cont_signal  = 1'b1;
        @(posedge Clck);
        #1;
        chk("out_cont_clear", bus.out_cont_signal, 0);
        chk("busy_idle", bus.busy, 0);
        bus.next_fin_signal = 1'b0;
        bus.in_cont_signal  = 1'b0;
        @(posedge Clck);
        #1;
        chk("no_restart", bus.busy, 0);
        $display("fill x=%0d y=%0d w=%0d h=%0d color=%0d noise=%0d writes=%0d expected=%0d",
                 x, y, w, h, c, noise, wr_count - base_cnt, n);
    endtask

    task automatic run_reset_abort();
        int n, cnt, base_cnt;
        push_expected(5, 5, 4, 4, 3, n);
        start_fill(5, 5, 4, 4, 3);
        @(posedge Clck);
        #1;
        bus.in_cont_signal = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40 && cnt < 3; k++) begin
            @(posedge Clck);
            #2;
            if (bus.write_en === 1'b1) cnt++;
        end
        chk("rst_third_wr_seen", cnt, 3);
        Reset = 1'b0;
        #1;
        chk("rst_wen", bus.write_en, 0);
        chk("rst_addr", bus.write_addr, 0);
        chk("rst_data", bus.write_data, 0);
        chk("rst_out_cont", bus.out_cont_signal, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pops", n - sb.size(), 2);
        sb.delete();
        @(negedge Clck);
        Reset    = 1'b1;
        base_cnt = wr_count;
        repeat (30) @(posedge Clck);
        #1;
        chk("post_rst_no_wr", wr_count - base_cnt, 0);
        chk("post_rst_out_cont", bus.out_cont_signal, 0);
        chk("post_rst_busy", bus.busy, 0);
        $display("reset abort during 4x4 fill: writes before reset=%0d", cnt);
    endtask

    initial begin
        bus.in_cont_signal  = 1'b0;
        bus.next_fin_signal = 1'b0;
        bus.rect_x          = '0;
        bus.rect_y          = '0;
        bus.rect_w          = '0;
        bus.rect_h          = '0;
        bus.rect_color      = '0;
        #12;
        chk("reset_addr", bus.write_addr, 0);
        chk("reset_data", bus.write_data, 0);
        chk("reset_wen", bus.write_en, 0);
        chk("reset_out_cont", bus.out_cont_signal, 0);
        chk("reset_busy", bus.busy, 0);
        @(negedge Clck);
        Reset = 1'b1;

        run_fill(10, 20, 2, 2, 5, 1'b0);
        run_fill(110, 111, 5, 3, 6, 1'b0);
        run_fill(30, 40, 0, 5, 7, 1'b0);
        run_fill(50, 60, 3, 0, 1, 1'b0);
        run_fill(112, 10, 3, 3, 2, 1'b0);
        run_fill(3, 112, 3, 3, 2, 1'b0);
        run_fill(100, 105, 20, 20, 1, 1'b0);
        run_fill(7, 9, 4, 4, 6, 1'b1);
        run_fill(0, 0, 112, 112, 4, 1'b0);
        run_reset_abort();
        run_fill(1, 2, 3, 2, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
